// File: rtl/bram_axi_rr_if.sv
// AXI4-style slave bus bundle for bram_axi_rr: AW/W/B/AR/R channels.
// The master modport drives requests, the slave modport drives responses.
interface bram_axi_rr_if #(
    parameter int AXI_WIDTH_SID = 8,
    parameter int AXI_WIDTH_AD  = 32,
    parameter int AXI_WIDTH_DA  = 32
);
    localparam int AXI_WIDTH_DS = AXI_WIDTH_DA / 8;

    logic [AXI_WIDTH_SID-1:0] AWID;
    logic [AXI_WIDTH_AD-1:0]  AWADDR;
    logic [3:0]               AWLEN;
    logic [2:0]               AWSIZE;
    logic [1:0]               AWBURST;
    logic                     AWVALID;
    logic                     AWREADY;
    logic [AXI_WIDTH_DA-1:0]  WDATA;
    logic [AXI_WIDTH_DS-1:0]  WSTRB;
    logic                     WLAST;
    logic                     WVALID;
    logic                     WREADY;
    logic [AXI_WIDTH_SID-1:0] BID;
    logic [1:0]               BRESP;
    logic                     BVALID;
    logic                     BREADY;
    logic [AXI_WIDTH_SID-1:0] ARID;
    logic [AXI_WIDTH_AD-1:0]  ARADDR;
    logic [3:0]               ARLEN;
    logic [2:0]               ARSIZE;
    logic [1:0]               ARBURST;
    logic                     ARVALID;
    logic                     ARREADY;
    logic [AXI_WIDTH_SID-1:0] RID;
    logic [AXI_WIDTH_DA-1:0]  RDATA;
    logic [1:0]               RRESP;
    logic                     RLAST;
    logic                     RVALID;
    logic                     RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID, BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/bram_axi_rr.sv
// Single-port block RAM behind an AXI slave; one transaction at a time,
// round-robin arbitration between the write and read address channels.
module bram_axi_rr #(
    parameter int AXI_WIDTH_SID   = 8,
    parameter int AXI_WIDTH_AD    = 32,
    parameter int AXI_WIDTH_DA    = 32,
    parameter int P_SIZE_IN_BYTES = 8192
) (
    input logic          ACLK,
    input logic          ARESET,
    bram_axi_rr_if.slave axi
);
    localparam int AW    = AXI_WIDTH_AD;
    localparam int DS    = AXI_WIDTH_DA / 8;
    localparam int BW    = $clog2(DS);
    localparam int DEPTH = P_SIZE_IN_BYTES / DS;
    localparam int IW    = $clog2(DEPTH);
    localparam logic [2:0]    MAX_SIZE = 3'(BW);
    localparam logic [AW-1:0] MEM_END  = AW'(P_SIZE_IN_BYTES);
    localparam logic [1:0]    BURST_FIXED = 2'b00;
    localparam logic [1:0]    BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, WR, WRESP, RD} state_t;

    function automatic logic wrap_len_ok(input logic [3:0] ln);
        return ln == 4'd1 || ln == 4'd3 || ln == 4'd7 || ln == 4'd15;
    endfunction

    function automatic logic bad_txn(input logic [2:0] sz, input logic [3:0] ln,
                                     input logic [1:0] bt);
        return (sz > MAX_SIZE) || (bt == BURST_WRAP && !wrap_len_ok(ln));
    endfunction

    // Illegal WRAP lengths fall through to INCR stepping.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] sz,
                                                input logic [3:0] ln, input logic [1:0] bt);
        logic [AW-1:0] inc, mask;
        inc  = AW'(1) << sz;
        mask = inc * (AW'(ln) + AW'(1)) - AW'(1);
        if (bt == BURST_FIXED) return a;
        if (bt == BURST_WRAP && wrap_len_ok(ln)) return (a & ~mask) | ((a + inc) & mask);
        return a + inc;
    endfunction

    state_t                   state;
    logic                     rr_ptr;   // 0: write wins a tie, 1: read wins
    logic                     err;
    logic [AXI_WIDTH_SID-1:0] id;
    logic [AW-1:0]            addr;
    logic [3:0]               len, beat;
    logic [2:0]               size;
    logic [1:0]               burst, bresp, rresp;
    logic                     rd_done, rvalid, rlast, rd_zero;
    logic [AXI_WIDTH_DA-1:0]  mem_q;
    logic [AXI_WIDTH_DA-1:0]  mem [DEPTH];

    logic grant_w, grant_r, aw_fire, ar_fire, w_fire, rd_issue, in_range, beat_last, err_nxt;
    logic [IW-1:0] word;

    assign grant_w   = axi.AWVALID && (!axi.ARVALID || !rr_ptr);
    assign grant_r   = axi.ARVALID && !grant_w;
    assign aw_fire   = axi.AWVALID && axi.AWREADY;
    assign ar_fire   = axi.ARVALID && axi.ARREADY;
    assign w_fire    = axi.WVALID && axi.WREADY;
    assign in_range  = addr < MEM_END;
    assign beat_last = beat == len;
    assign word      = addr[IW+BW-1:BW];
    assign rd_issue  = state == RD && !rd_done && (!rvalid || axi.RREADY) && !ARESET;
    assign err_nxt   = err || !in_range || (axi.WLAST != beat_last);

    assign axi.AWREADY = state == IDLE && !ARESET && grant_w;
    assign axi.ARREADY = state == IDLE && !ARESET && grant_r;
    assign axi.WREADY  = state == WR && !ARESET;
    assign axi.BVALID  = state == WRESP && !ARESET;
    assign axi.BID     = id;
    assign axi.BRESP   = bresp;
    assign axi.RID     = id;
    assign axi.RDATA   = rd_zero ? '0 : mem_q;
    assign axi.RRESP   = rresp;
    assign axi.RLAST   = rlast;
    assign axi.RVALID  = rvalid;

    // Memory is never reset, so beats written before an abort survive it.
    always_ff @(posedge ACLK) begin
        if (w_fire && in_range)
            for (int b = 0; b < DS; b++)
                if (axi.WSTRB[b]) mem[word][b*8 +: 8] <= axi.WDATA[b*8 +: 8];
        if (rd_issue) mem_q <= mem[word];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= IDLE;
            rr_ptr  <= 1'b0;
            err     <= 1'b0;
            id      <= '0;
            addr    <= '0;
            len     <= '0;
            size    <= '0;
            burst   <= '0;
            beat    <= '0;
            rd_done <= 1'b0;
            bresp   <= 2'b00;
            rresp   <= 2'b00;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rd_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat    <= '0;
                    rd_done <= 1'b0;
                    if (axi.AWVALID && axi.ARVALID && (aw_fire || ar_fire)) rr_ptr <= aw_fire;
                    if (aw_fire) begin
                        id    <= axi.AWID;
                        addr  <= axi.AWADDR;
                        len   <= axi.AWLEN;
                        size  <= axi.AWSIZE;
                        burst <= axi.AWBURST;
                        err   <= bad_txn(axi.AWSIZE, axi.AWLEN, axi.AWBURST);
                        state <= WR;
                    end else if (ar_fire) begin
                        id    <= axi.ARID;
                        addr  <= axi.ARADDR;
                        len   <= axi.ARLEN;
                        size  <= axi.ARSIZE;
                        burst <= axi.ARBURST;
                        err   <= bad_txn(axi.ARSIZE, axi.ARLEN, axi.ARBURST);
                        state <= RD;
                    end
                end
                WR: if (w_fire) begin
                    err  <= err_nxt;
                    addr <= next_addr(addr, size, len, burst);
                    beat <= beat + 4'd1;
                    if (beat_last) begin
                        bresp <= err_nxt ? 2'b10 : 2'b00;
                        state <= WRESP;
                    end
                end
                WRESP: if (axi.BREADY) begin
                    bresp <= 2'b00;
                    state <= IDLE;
                end
                RD: begin
                    // Output register doubles as the BRAM read port; refill when empty or drained.
                    if (rd_issue) begin
                        rvalid  <= 1'b1;
                        rlast   <= beat_last;
                        rresp   <= (err || !in_range) ? 2'b10 : 2'b00;
                        rd_zero <= !in_range;
                        addr    <= next_addr(addr, size, len, burst);
                        beat    <= beat + 4'd1;
                        rd_done <= beat_last;
                    end else if (axi.RREADY) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                    end
                    if (rvalid && axi.RREADY && rlast) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_axi_rr.sv
// Directed bench for bram_axi_rr: expected B/R responses are queued when
// requests are driven and checked as the DUT returns them.
module tb_bram_axi_rr;
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    bram_axi_rr_if axi ();
    bram_axi_rr dut (.ACLK(ACLK), .ARESET(ARESET), .axi(axi));

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    rexp_t      rq[$];
    logic [1:0] bq[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l);
        rexp_t e;
        e.data = d; e.resp = r; e.last = l;
        rq.push_back(e);
    endtask

    // All bus tasks start and return on a falling edge.
    task automatic send_aw(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [7:0] id);
        int i = 0;
        axi.AWADDR = a; axi.AWLEN = l; axi.AWSIZE = s; axi.AWBURST = b; axi.AWID = id;
        axi.AWVALID = 1'b1;
        #1;
        while (!axi.AWREADY && i < 20) begin @(negedge ACLK); #1; i++; end
        chk("aw_ready", 32'(axi.AWREADY), 1);
        @(negedge ACLK);
        axi.AWVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [7:0] id);
        int i = 0;
        axi.ARADDR = a; axi.ARLEN = l; axi.ARSIZE = s; axi.ARBURST = b; axi.ARID = id;
        axi.ARVALID = 1'b1;
        #1;
        while (!axi.ARREADY && i < 20) begin @(negedge ACLK); #1; i++; end
        chk("ar_ready", 32'(axi.ARREADY), 1);
        @(negedge ACLK);
        axi.ARVALID = 1'b0;
    endtask

    // Sends nb beats of a burst whose declared length is len.
    task automatic wr_data(input int nb, input int len, input logic [31:0] d0, input logic [3:0] strb);
        for (int k = 0; k < nb; k++) begin
            int i = 0;
            axi.WDATA = d0 + 32'(k); axi.WSTRB = strb; axi.WLAST = (k == len); axi.WVALID = 1'b1;
            #1;
            while (!axi.WREADY && i < 20) begin @(negedge ACLK); #1; i++; end
            chk("w_ready", 32'(axi.WREADY), 1);
            @(negedge ACLK);
        end
        axi.WVALID = 1'b0; axi.WLAST = 1'b0;
    endtask

    task automatic b_check(input logic [7:0] id);
        int i = 0;
        logic [1:0] e = 2'bxx;
        axi.BREADY = 1'b1;
        #1;
        while (!axi.BVALID && i < 20) begin @(negedge ACLK); #1; i++; end
        chk("b_valid", 32'(axi.BVALID), 1);
        if (bq.size() > 0) e = bq.pop_front();
        chk("bresp", 32'(axi.BRESP), 32'(e));
        chk("bid", 32'(axi.BID), 32'(id));
        @(negedge ACLK);
        axi.BREADY = 1'b0;
    endtask

    // Called on the first falling edge after the AR handshake. pat gives RREADY
    // per cycle, counted from the first cycle RVALID is seen.
    task automatic rd_recv(input int nbeats, input logic [7:0] pat, input logic [7:0] id);
        int cyc = 1, got = 0, pidx = 0;
        logic started = 1'b0, stalled = 1'b0;
        logic [31:0] pd = '0;
        rexp_t e;
        while (got < nbeats && cyc < 100) begin
            #1;
            if (axi.RVALID && !started) begin
                started = 1'b1;
                chk("r_latency", 32'(cyc), 2);
                chk("rid", 32'(axi.RID), 32'(id));
            end
            axi.RREADY = started ? (pidx < 8 ? pat[pidx] : 1'b1) : 1'b0;
            if (stalled) begin
                chk("r_stall_valid", 32'(axi.RVALID), 1);
                chk("r_stall_data", axi.RDATA, pd);
            end
            if (axi.RVALID && axi.RREADY) begin
                e.data = 'x; e.resp = 'x; e.last = 1'bx;
                if (rq.size() > 0) e = rq.pop_front();
                chk("rdata", axi.RDATA, e.data);
                chk("rresp", 32'(axi.RRESP), 32'(e.resp));
                chk("rlast", 32'(axi.RLAST), 32'(e.last));
                got++;
                stalled = 1'b0;
            end else if (axi.RVALID) begin
                stalled = 1'b1;
                pd = axi.RDATA;
            end
            if (started) pidx++;
            @(negedge ACLK);
            cyc++;
        end
        axi.RREADY = 1'b0;
        chk("r_beats", 32'(got), 32'(nbeats));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0;
        axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;
        axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0; axi.ARBURST = '0;
        axi.AWVALID = 1'b1; axi.ARVALID = 1'b1; axi.RREADY = 1'b0;

        // Reset state, with both address channels requesting.
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_awready", 32'(axi.AWREADY), 0);
        chk("rst_arready", 32'(axi.ARREADY), 0);
        chk("rst_wready", 32'(axi.WREADY), 0);
        chk("rst_bvalid", 32'(axi.BVALID), 0);
        chk("rst_rvalid", 32'(axi.RVALID), 0);
        chk("rst_rlast", 32'(axi.RLAST), 0);
        chk("rst_bresp", 32'(axi.BRESP), 0);
        chk("rst_rresp", 32'(axi.RRESP), 0);
        @(negedge ACLK);
        axi.AWVALID = 1'b0; axi.ARVALID = 1'b0; ARESET = 1'b0;
        @(negedge ACLK);

        // Two contested requests: write wins first, read second.
        axi.AWADDR = 32'h40; axi.AWLEN = 4'd0; axi.AWSIZE = 3'd2; axi.AWBURST = 2'b01; axi.AWID = 8'h11;
        axi.ARADDR = 32'h40; axi.ARLEN = 4'd0; axi.ARSIZE = 3'd2; axi.ARBURST = 2'b01; axi.ARID = 8'h22;
        axi.AWVALID = 1'b1; axi.ARVALID = 1'b1;
        #1;
        chk("rr1_awready", 32'(axi.AWREADY), 1);
        chk("rr1_arready", 32'(axi.ARREADY), 0);
        @(negedge ACLK);
        axi.AWVALID = 1'b0; axi.ARVALID = 1'b0;
        bq.push_back(2'b00);
        wr_data(1, 0, 32'h55, 4'hF);
        b_check(8'h11);
        axi.AWVALID = 1'b1; axi.ARVALID = 1'b1;
        #1;
        chk("rr2_arready", 32'(axi.ARREADY), 1);
        chk("rr2_awready", 32'(axi.AWREADY), 0);
        @(negedge ACLK);
        axi.AWVALID = 1'b0; axi.ARVALID = 1'b0;
        push_r(32'h55, 2'b00, 1'b1);
        rd_recv(1, 8'hFF, 8'h22);

        // INCR write 1..4 at 0x10 and read back.
        bq.push_back(2'b00);
        send_aw(32'h10, 4'd3, 3'd2, 2'b01, 8'h01);
        wr_data(4, 3, 32'd1, 4'hF);
        b_check(8'h01);
        for (int k = 1; k <= 4; k++) push_r(32'(k), 2'b00, k == 4);
        send_ar(32'h10, 4'd3, 3'd2, 2'b01, 8'h02);
        rd_recv(4, 8'hFF, 8'h02);

        // WRAP from 0x1C visits 0x1C, 0x10, 0x14, 0x18.
        push_r(32'd4, 2'b00, 1'b0); push_r(32'd1, 2'b00, 1'b0);
        push_r(32'd2, 2'b00, 1'b0); push_r(32'd3, 2'b00, 1'b1);
        send_ar(32'h1C, 4'd3, 3'd2, 2'b10, 8'h03);
        rd_recv(4, 8'hFF, 8'h03);

        // FIXED read repeats one word.
        push_r(32'd2, 2'b00, 1'b0); push_r(32'd2, 2'b00, 1'b1);
        send_ar(32'h14, 4'd1, 3'd2, 2'b00, 8'h04);
        rd_recv(2, 8'hFF, 8'h04);

        // Byte strobes: only the low two bytes of 0x10 change.
        bq.push_back(2'b00);
        send_aw(32'h10, 4'd0, 3'd2, 2'b01, 8'h05);
        wr_data(1, 0, 32'hFFFF_FFFF, 4'h3);
        b_check(8'h05);
        push_r(32'h0000_FFFF, 2'b00, 1'b1);
        send_ar(32'h10, 4'd0, 3'd2, 2'b01, 8'h06);
        rd_recv(1, 8'hFF, 8'h06);

        // Illegal WRAP length: SLVERR on every beat, INCR stepping.
        push_r(32'h0000_FFFF, 2'b10, 1'b0); push_r(32'd2, 2'b10, 1'b0); push_r(32'd3, 2'b10, 1'b1);
        send_ar(32'h10, 4'd2, 3'd2, 2'b10, 8'h07);
        rd_recv(3, 8'hFF, 8'h07);

        // Oversized AxSIZE: SLVERR but data still moves, addresses step by 8.
        bq.push_back(2'b10);
        send_aw(32'h80, 4'd1, 3'd3, 2'b01, 8'h08);
        wr_data(2, 1, 32'h900, 4'hF);
        b_check(8'h08);
        push_r(32'h900, 2'b10, 1'b0); push_r(32'h901, 2'b10, 1'b1);
        send_ar(32'h80, 4'd1, 3'd3, 2'b01, 8'h09);
        rd_recv(2, 8'hFF, 8'h09);

        // Burst running off the end of memory.
        bq.push_back(2'b10);
        send_aw(32'd8188, 4'd1, 3'd2, 2'b01, 8'h0A);
        wr_data(2, 1, 32'hAA, 4'hF);
        b_check(8'h0A);
        push_r(32'hAA, 2'b00, 1'b0); push_r(32'h0, 2'b10, 1'b1);
        send_ar(32'd8188, 4'd1, 3'd2, 2'b01, 8'h0B);
        rd_recv(2, 8'hFF, 8'h0B);

        // RREADY 1,0,0,1 backpressure.
        bq.push_back(2'b00);
        send_aw(32'h100, 4'd3, 3'd2, 2'b01, 8'h0C);
        wr_data(4, 3, 32'h11, 4'hF);
        b_check(8'h0C);
        for (int k = 0; k < 4; k++) push_r(32'h11 + 32'(k), 2'b00, k == 3);
        send_ar(32'h100, 4'd3, 3'd2, 2'b01, 8'h0D);
        rd_recv(4, 8'b1111_1001, 8'h0D);

        // Reset after two of four write beats: no response, data kept.
        send_aw(32'h200, 4'd3, 3'd2, 2'b01, 8'h0E);
        wr_data(2, 3, 32'h77, 4'hF);
        #1;
        chk("abort_bvalid0", 32'(axi.BVALID), 0);
        @(negedge ACLK);
        ARESET = 1'b1;
        repeat (2) begin
            @(negedge ACLK);
            #1;
            chk("abort_bvalid_rst", 32'(axi.BVALID), 0);
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        axi.AWADDR = 32'h300; axi.AWLEN = 4'd0; axi.AWSIZE = 3'd2; axi.AWBURST = 2'b01; axi.AWID = 8'h0F;
        axi.AWVALID = 1'b1;
        #1;
        chk("abort_bvalid_idle", 32'(axi.BVALID), 0);
        chk("abort_awready", 32'(axi.AWREADY), 1);
        @(negedge ACLK);
        axi.AWVALID = 1'b0;
        bq.push_back(2'b00);
        wr_data(1, 0, 32'h33, 4'hF);
        b_check(8'h0F);
        push_r(32'h77, 2'b00, 1'b0); push_r(32'h78, 2'b00, 1'b1);
        send_ar(32'h200, 4'd1, 3'd2, 2'b01, 8'h10);
        rd_recv(2, 8'hFF, 8'h10);

        chk("rq_drained", 32'(rq.size()), 0);
        chk("bq_drained", 32'(bq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
